// File: rtl/mig_node_if.sv
// mig_node_if: descriptor handshake bus feeding the MIG node evaluator.
interface mig_node_if #(
    parameter int IDX_W = 8
) ();
    logic             desc_valid;
    logic             desc_ready;
    logic [IDX_W-1:0] desc_a;
    logic [IDX_W-1:0] desc_b;
    logic [IDX_W-1:0] desc_c;
    logic [2:0]       desc_inv;
    logic             desc_last;
    logic             desc_out_inv;
    modport master (
        output desc_valid, desc_a, desc_b, desc_c, desc_inv, desc_last, desc_out_inv,
        input  desc_ready
    );
    modport slave (
        input  desc_valid, desc_a, desc_b, desc_c, desc_inv, desc_last, desc_out_inv,
        output desc_ready
    );
endinterface

// File: rtl/mig_node_evaluator.sv
// mig_node_evaluator: replays a topologically ordered MIG netlist against a latched PI vector.
module mig_node_evaluator #(
    parameter int NUM_PI    = 4,
    parameter int MAX_NODES = 128,
    parameter int IDX_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_PI-1:0] pi,
    mig_node_if.slave         d,
    output logic              busy,
    output logic              po,
    output logic              po_valid,
    output logic              err,
    output logic [IDX_W-1:0]  node_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, nxt;
    logic             vals [2**IDX_W];
    logic             go, acc, bad, va, vb, vc, res;
    logic [IDX_W-1:0] lim;
    assign d.desc_ready = state == RUN;
    assign busy         = state == RUN;
    assign po_valid     = state == DONE;
    // Anything at or above lim is not yet defined: forward, self or out-of-range reference.
    always_comb begin
        go  = state == IDLE && start;
        acc = d.desc_valid && d.desc_ready;
        lim = IDX_W'(NUM_PI + 1) + node_count;
        va  = vals[d.desc_a] ^ d.desc_inv[0];
        vb  = vals[d.desc_b] ^ d.desc_inv[1];
        vc  = vals[d.desc_c] ^ d.desc_inv[2];
        res = (va & vb) | (va & vc) | (vb & vc);
        bad = d.desc_a >= lim || d.desc_b >= lim || d.desc_c >= lim ||
              node_count == IDX_W'(MAX_NODES);
        nxt = go ? RUN :
              state == DONE ? IDLE :
              acc && bad ? IDLE :
              acc && d.desc_last ? DONE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            po         <= 1'b0;
            err        <= 1'b0;
            node_count <= '0;
        end else begin
            state <= nxt;
            if (go) begin
                err        <= 1'b0;
                node_count <= '0;
            end
            if (acc && bad) err <= 1'b1;
            if (acc && !bad) node_count <= node_count + 1'b1;
            if (acc && !bad && d.desc_last) po <= res ^ d.desc_out_inv;
        end
    end
    // Value store: slot 0 is constant 0, then the PIs, then gate results; never cleared.
    always_ff @(posedge clk) begin
        if (go) begin
            vals[0] <= 1'b0;
            for (int i = 0; i < NUM_PI; i++) vals[IDX_W'(i + 1)] <= pi[i];
        end
        if (acc && !bad) vals[lim] <= res;
    end
endmodule

// File: doc/mig_node_evaluator.md
# mig_node_evaluator

Streaming evaluator for majority-inverter graph (MIG) netlists. It accepts a topologically ordered stream of 3-input majority node descriptors, evaluates each against a latched primary-input vector, and returns the value of the designated output node. It is the consuming end of the MIG netlists our flow emits: the bench and on-chip checker use it to replay a synthesized netlist node by node and compare against the golden function.

## Interface
Parameters:
- NUM_PI, 4, number of primary inputs
- MAX_NODES, 128, capacity of the gate-node value store
- IDX_W, 8, operand index width; 1+NUM_PI+MAX_NODES ≤ 2^IDX_W required

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin evaluation; honoured only in IDLE
- pi  in  NUM_PI  primary input values, sampled on accepted start
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accept
- desc_a / desc_b / desc_c  in  IDX_W each  operand node indices
- desc_inv  in  3  operand complement bits (bit0=a, bit1=b, bit2=c)
- desc_last  in  1  this node drives the output
- desc_out_inv  in  1  complement applied to po, used only with desc_last
- busy  out  1  high in RUN
- po  out  1  evaluated output, held until next start
- po_valid  out  1  one-cycle pulse when po updates
- err  out  1  sticky error, cleared by next accepted start or rst
- node_count  out  IDX_W  gate nodes accepted in current run

## Operation
- Index space: 0 = constant 0 (constant 1 = index 0 complemented); 1..NUM_PI = pi[0]..pi[NUM_PI-1]; NUM_PI+1+k = k-th accepted gate node.
- States: IDLE, RUN, DONE.
- IDLE: desc_ready=0, busy=0. start=1 → latch pi, node_count=0, err=0 → RUN. start in RUN/DONE ignored.
- RUN: desc_ready=1. On desc_valid & desc_ready: each operand value = store[idx] XOR inv bit; result = maj(a,b,c) = ab|ac|bc; write to slot NUM_PI+1+node_count; node_count+1.
- desc_last on an accepted, error-free descriptor → po = result XOR desc_out_inv → DONE.
- DONE: po_valid=1 for exactly this cycle, desc_ready=0 → IDLE.
- Error conditions, checked on the accepting cycle: any operand index ≥ NUM_PI+1+node_count (forward/self reference or out of range); node_count == MAX_NODES at accept. On error: err=1, no write, po unchanged, no po_valid, → IDLE. The descriptor is still consumed (handshake completes).
- Store contents beyond node_count are don't-care; no clearing between runs.

## Timing
- Reset values: state IDLE, desc_ready=0, busy=0, po=0, po_valid=0, err=0, node_count=0.
- rst mid-run: abort immediately, all outputs to reset values, partial results discarded.
- start → RUN on next edge; desc_ready high the cycle after start accepted.
- Throughput: one descriptor per cycle; operand reads are combinational from flop store, so node k may reference node k-1 accepted the previous cycle.
- Latency: po/po_valid registered; po_valid high the cycle after the desc_last handshake.
- Minimum run (one node): start at cycle 0, accept at cycle 1, po_valid at cycle 2, IDLE at cycle 3.
- desc_valid while desc_ready=0: held by sender, not consumed.

## Test plan
- Single node maj(pi0,pi1,pi2), indices 1,2,3, inv=0, last, pi=4'b0011 → po=1, po_valid pulse at cycle 2; pi=4'b0001 → po=0.
- OR via constant: node maj(idx0 inv=1, pi0, pi1) = pi0|pi1, pi=4'b0000 → po=0, pi=4'b0010 → po=1; desc_out_inv=1 inverts both.
- Chain: n5=maj(1,2,0), n6=maj(5,3,0 inv), n7=maj(5,6,4) last, back-to-back valid, all 16 pi patterns vs software model → match; node_count=3.
- Forward reference: first descriptor references index 5 → err=1, no po_valid, back to IDLE; next start clears err.
- Overflow: MAX_NODES=4 build, 5 descriptors without last → err on 5th, po unchanged.
- rst asserted mid-stream with desc_valid high → desc_ready=0, busy=0, node_count=0 next cycle; subsequent run correct.
